// File: rtl/pam_demod_pilot.sv
// pam_demod_pilot: pilot-trained PAM-4 slicer with symbol packing and a small output byte FIFO
module pam_demod_pilot #(
  parameter int AD_CVER_WIDTH = 12,
  parameter int LENGTH_DATA   = 1024,
  parameter int NUM_PILOT     = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     syn_demodu_valid,
  input  logic [AD_CVER_WIDTH-1:0] syn_demodu_data,
  output logic                     syn_demodu_ready,
  output logic                     demod_valid,
  output logic [7:0]               demod_data,
  input  logic                     demod_ready,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     overflow
);
  localparam int W  = AD_CVER_WIDTH;
  localparam int DW = $clog2(LENGTH_DATA);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PILOT, DATA, DRAIN} state_t;
  state_t         state;
  logic [W-1:0]   p [NUM_PILOT];
  logic [1:0]     pcnt;
  logic [DW-1:0]  dcnt;
  logic [1:0]     scnt;
  logic [5:0]     sr;
  logic [W-1:0]   t01, t12, t23;
  logic           push;
  logic [7:0]     pbyte;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wp, rp;
  logic [AW:0]    cnt;
  logic [1:0]     sym;
  logic           ord_ok, pop, full, wr;

  // midpoint of two levels, truncated, without losing the carry
  function automatic logic [W-1:0] mid(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W:1];
  endfunction

  // slicer decision, pilot ordering test and FIFO handshake terms; ties fall to the lower symbol
  always_comb begin
    sym    = (syn_demodu_data > t23) ? 2'd3 :
             (syn_demodu_data > t12) ? 2'd2 :
             (syn_demodu_data > t01) ? 2'd1 : 2'd0;
    ord_ok = (p[0] < p[1]) && (p[1] < p[2]) && (p[2] < syn_demodu_data);
    full   = cnt == (AW+1)'(FIFO_DEPTH);
    pop    = demod_valid & demod_ready;
    wr     = push & (~full | pop);
  end

  assign demod_valid = cnt != '0;
  assign demod_data  = demod_valid ? mem[rp] : 8'h00;

  // frame FSM: pilot capture, threshold latch, slicing/packing and status pulses
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state            <= IDLE;
      pcnt             <= '0;
      dcnt             <= '0;
      scnt             <= '0;
      sr               <= '0;
      t01              <= '0;
      t12              <= '0;
      t23              <= '0;
      push             <= 1'b0;
      pbyte            <= '0;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
      syn_demodu_ready <= 1'b0;
      for (int i = 0; i < NUM_PILOT; i++) p[i] <= '0;
    end else begin
      syn_demodu_ready <= 1'b1;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
      push             <= 1'b0;
      case (state)
        IDLE: if (syn_demodu_valid) begin
          p[0]  <= syn_demodu_data;
          pcnt  <= 2'd1;
          state <= PILOT;
        end
        PILOT: if (!syn_demodu_valid) begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end else begin
          p[pcnt] <= syn_demodu_data;
          pcnt    <= pcnt + 1'b1;
          if (pcnt == 2'(NUM_PILOT-1)) begin
            if (ord_ok) begin
              t01   <= mid(p[0], p[1]);
              t12   <= mid(p[1], p[2]);
              t23   <= mid(p[2], syn_demodu_data);
              dcnt  <= '0;
              scnt  <= '0;
              state <= DATA;
            end else begin
              frame_err <= 1'b1;
              state     <= DRAIN;
            end
          end
        end
        DATA: if (!syn_demodu_valid) begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end else begin
          sr   <= {sr[3:0], sym};
          scnt <= scnt + 1'b1;
          dcnt <= dcnt + 1'b1;
          if (scnt == 2'd3) begin
            push  <= 1'b1;
            pbyte <= {sr, sym};
          end
          if (dcnt == DW'(LENGTH_DATA-1)) begin
            frame_done <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: if (!syn_demodu_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow; a pop frees the slot for a same-cycle push
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push & full & ~pop) overflow <= 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end

  // FIFO storage, no reset needed since the head is masked while empty
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= pbyte;
  end
endmodule

// File: tb/tb_pam_demod_pilot.sv
// tb_pam_demod_pilot: randomized scoreboard bench for pam_demod_pilot
module tb_pam_demod_pilot;
  localparam int L = 1024;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        v = 1'b0;
  logic [11:0] d = '0;
  logic        ready;
  logic        dv;
  logic [7:0]  dd;
  logic        dr = 1'b1;
  logic        fd, fe, ov;
  int          checks = 0, passes = 0;
  int          n_done = 0, n_err = 0, exp_done = 0, exp_err = 0;
  logic [7:0]  q[$];
  logic        held_v = 1'b0;
  logic [7:0]  held;
  int          gp[4];
  int          gq[$];

  pam_demod_pilot dut (
    .clk(clk), .arst_n(arst_n),
    .syn_demodu_valid(v), .syn_demodu_data(d), .syn_demodu_ready(ready),
    .demod_valid(dv), .demod_data(dd), .demod_ready(dr),
    .frame_done(fd), .frame_err(fe), .overflow(ov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference slicer: midpoints of adjacent pilot levels, ties go low
  function automatic int sym(input int x, input int pl[4]);
    int t01, t12, t23;
    t01 = (pl[0] + pl[1]) / 2;
    t12 = (pl[1] + pl[2]) / 2;
    t23 = (pl[2] + pl[3]) / 2;
    return x > t23 ? 3 : x > t12 ? 2 : x > t01 ? 1 : 0;
  endfunction

  // monitor: pops expected bytes on every handshake, checks head stability and status pulses
  always @(negedge clk) begin
    if (arst_n) begin
      if (held_v && dv) chk("hold_stable", dd, held);
      held_v = dv && !dr;
      held = dd;
      if (dv && dr) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %0d expected none", dd);
        end else chk("byte", dd, q.pop_front());
      end
      if (fd) n_done++;
      if (fe) n_err++;
      if (fd || fe) chk("done_err_exclusive", fd & fe, 0);
    end else held_v = 1'b0;
  end

  task automatic send(input int x);
    v = 1'b1;
    d = 12'(x);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    v = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic gen();
    gp[0] = $urandom_range(0, 900);
    for (int i = 1; i < 4; i++) gp[i] = gp[i-1] + $urandom_range(1, 1000);
    gq.delete();
    for (int i = 0; i < L; i++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) gq.push_back((gp[$urandom_range(0, 2)] + gp[$urandom_range(1, 3)]) / 2 + $urandom_range(0, 1));
      else gq.push_back($urandom_range(0, 4095));
    end
  endtask

  task automatic run_frame(input int pl[4], input int dq[$], input int nsend, input int keep,
                           input bit ovchk, input bit hold_valid);
    logic [7:0] b;
    int nb;
    b = 8'h00;
    nb = 0;
    for (int k = 0; k < nsend; k++) begin
      b = b | 8'(sym(dq[k], pl) << (6 - 2 * (k % 4)));
      if (k % 4 == 3) begin
        if (nb < keep) q.push_back(b);
        nb++;
        b = 8'h00;
      end
    end
    for (int i = 0; i < 4; i++) send(pl[i]);
    for (int i = 0; i < nsend; i++) begin
      if (ovchk && i == 19) chk("overflow_before_5th", ov, 0);
      send(dq[i]);
    end
    if (nsend == L) begin
      chk("frame_done", fd, 1);
      chk("frame_err_clear", fe, 0);
      exp_done++;
      idle();
      chk("done_one_cycle", fd, 0);
    end else if (!hold_valid) begin
      idle();
      chk("abort_err", fe, 1);
      exp_err++;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (q.size() != 0 || dv); i++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int pl[4];
    int dq[$];
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_valid", dv, 0);
    chk("rst_data", dd, 0);
    chk("rst_done", fd, 0);
    chk("rst_err", fe, 0);
    chk("rst_ovf", ov, 0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", ready, 1);
    pl = '{400, 1200, 2000, 2800};
    dq.delete();
    for (int i = 0; i < L / 4; i++) begin
      dq.push_back(100); dq.push_back(1000); dq.push_back(1700); dq.push_back(3000);
    end
    run_frame(pl, dq, L, 1000, 1'b0, 1'b0);
    dq.delete();
    for (int i = 0; i < L / 4; i++) begin
      dq.push_back(800); dq.push_back(1600); dq.push_back(2400); dq.push_back(2401);
    end
    run_frame(pl, dq, L, 1000, 1'b0, 1'b0);
    wait_drain();
    send(1200); send(400); send(2000); send(2800);
    chk("bad_pilot_err", fe, 1);
    exp_err++;
    send($urandom_range(0, 4095));
    chk("bad_pilot_err_pulse", fe, 0);
    send($urandom_range(0, 4095));
    send($urandom_range(0, 4095));
    idle();
    chk("no_bytes_after_bad_pilot", q.size(), 0);
    gen();
    run_frame(gp, gq, L, 1000, 1'b0, 1'b0);
    gen();
    run_frame(gp, gq, 6, 1000, 1'b0, 1'b0);
    gen();
    run_frame(gp, gq, L, 1000, 1'b0, 1'b0);
    wait_drain();
    chk("ovf_clear_before", ov, 0);
    dr = 1'b0;
    gen();
    run_frame(gp, gq, L, 4, 1'b1, 1'b0);
    chk("ovf_set", ov, 1);
    chk("held_valid", dv, 1);
    dr = 1'b1;
    wait_drain();
    chk("ovf_sticky", ov, 1);
    gen();
    run_frame(gp, gq, 98, 1000, 1'b0, 1'b1);
    chk("pre_reset_queue", q.size(), 0);
    v = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_valid", dv, 0);
    chk("mid_rst_data", dd, 0);
    chk("mid_rst_done", fd, 0);
    chk("mid_rst_err", fe, 0);
    chk("mid_rst_ovf", ov, 0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    gen();
    run_frame(gp, gq, L, 1000, 1'b0, 1'b0);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", n_done, exp_done);
    chk("err_count", n_err, exp_err);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
